// File: rtl/dbf_line_sequencer_pkg.sv
// Shared widths, defaults and state encoding for the DBF scan-line sequencer.
package dbf_line_sequencer_pkg;

  // Default LUT address width, matching the channel dbf_lut_addr port.
  localparam int DBF_ADDR_WD    = 10;
  // Default width of the TX / RX / zone / write counters.
  localparam int DBF_CNT_WD     = 12;
  // Default line timing.
  localparam int DBF_NUM_ZONES  = 1024;
  localparam int DBF_TX_CYCLES  = 16;
  localparam int DBF_RX_SAMPLES = 2048;
  localparam int DBF_ZONE_LEN   = 2;

  // Sequencer state encoding.
  localparam int                   SEQ_ST_WD = 3;
  localparam logic [SEQ_ST_WD-1:0] ST_IDLE   = 3'd0;
  localparam logic [SEQ_ST_WD-1:0] ST_LOAD   = 3'd1;
  localparam logic [SEQ_ST_WD-1:0] ST_TX     = 3'd2;
  localparam logic [SEQ_ST_WD-1:0] ST_RX     = 3'd3;
  localparam logic [SEQ_ST_WD-1:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/dbf_line_sequencer_zone_addr_gen.sv
// RX read-address stepper: a zone tick counter plus a saturating LUT address.
// addr_nxt is the value the address takes at the coming clock edge, so the
// parent can register it straight into its output flop.
module dbf_zone_addr_gen
  import dbf_line_sequencer_pkg::*;
#(
  parameter int ADDR_WD   = DBF_ADDR_WD,
  parameter int CNT_WD    = DBF_CNT_WD,
  parameter int NUM_ZONES = DBF_NUM_ZONES,
  parameter int ZONE_LEN  = DBF_ZONE_LEN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  output logic [ADDR_WD-1:0] addr_nxt
);

  localparam logic [CNT_WD-1:0]  ZONE_LAST = CNT_WD'(ZONE_LEN - 1);
  localparam logic [ADDR_WD-1:0] ADDR_LAST = ADDR_WD'(NUM_ZONES - 1);

  logic [CNT_WD-1:0]  zone_cnt_r;
  logic [CNT_WD-1:0]  zone_cnt_s;
  logic [ADDR_WD-1:0] addr_r;
  logic [ADDR_WD-1:0] addr_s;

  // Address advances by one but sticks at the last zone instead of wrapping.
  function automatic logic [ADDR_WD-1:0] sat_inc(input logic [ADDR_WD-1:0] a);
    if (a == ADDR_LAST) begin
      return a;
    end else begin
      return a + ADDR_WD'(1);
    end
  endfunction

  // Next zone tick / address: clear wins, then step on enable, else hold.
  always_comb begin
    zone_cnt_s = zone_cnt_r;
    addr_s     = addr_r;
    if (clr) begin
      zone_cnt_s = '0;
      addr_s     = '0;
    end else if (en) begin
      if (zone_cnt_r == ZONE_LAST) begin
        zone_cnt_s = '0;
        addr_s     = sat_inc(addr_r);
      end else begin
        zone_cnt_s = zone_cnt_r + CNT_WD'(1);
        addr_s     = addr_r;
      end
    end else begin
      zone_cnt_s = zone_cnt_r;
      addr_s     = addr_r;
    end
  end

  // Zone tick and address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zone_cnt_r <= '0;
      addr_r     <= '0;
    end else begin
      zone_cnt_r <= zone_cnt_s;
      addr_r     <= addr_s;
    end
  end

  assign addr_nxt = addr_s;

endmodule

// File: rtl/dbf_line_sequencer.sv
// Per-scan-line controller for the DBF channel bank: loads the delay LUTs from
// the upstream loader, opens the transmit window, then the receive window while
// stepping the LUT read address per focal zone. Every output is a flop whose
// next value is derived from the next state, so outputs change with the state.
module dbf_line_sequencer
  import dbf_line_sequencer_pkg::*;
#(
  parameter int ADDR_WD    = DBF_ADDR_WD,
  parameter int NUM_ZONES  = DBF_NUM_ZONES,
  parameter int TX_CYCLES  = DBF_TX_CYCLES,
  parameter int RX_SAMPLES = DBF_RX_SAMPLES,
  parameter int ZONE_LEN   = DBF_ZONE_LEN,
  parameter int CNT_WD     = DBF_CNT_WD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               line_req,
  input  logic               abort,
  input  logic               ld_valid,
  output logic               ld_ready,
  output logic [ADDR_WD-1:0] dbf_lut_addr,
  output logic               dbf_lut_we,
  output logic               tx_en,
  output logic               start,
  output logic               busy,
  output logic               line_done
);

  localparam logic [CNT_WD-1:0] WR_ALL  = CNT_WD'(NUM_ZONES);
  localparam logic [CNT_WD-1:0] TX_LAST = CNT_WD'(TX_CYCLES - 1);
  localparam logic [CNT_WD-1:0] RX_LAST = CNT_WD'(RX_SAMPLES - 1);

  logic [SEQ_ST_WD-1:0] state_r;
  logic [SEQ_ST_WD-1:0] state_s;
  logic [CNT_WD-1:0]    wr_cnt_r;
  logic [CNT_WD-1:0]    wr_cnt_s;
  logic [CNT_WD-1:0]    tx_cnt_r;
  logic [CNT_WD-1:0]    tx_cnt_s;
  logic [CNT_WD-1:0]    rx_cnt_r;
  logic [CNT_WD-1:0]    rx_cnt_s;
  logic                 beat_s;
  logic                 zone_en_s;
  logic                 zone_clr_s;
  logic [ADDR_WD-1:0]   zone_addr_s;

  logic                 ld_ready_r;
  logic                 ld_ready_s;
  logic [ADDR_WD-1:0]   lut_addr_r;
  logic [ADDR_WD-1:0]   lut_addr_s;
  logic                 lut_we_r;
  logic                 lut_we_s;
  logic                 tx_en_r;
  logic                 tx_en_s;
  logic                 start_r;
  logic                 start_s;
  logic                 busy_r;
  logic                 busy_s;
  logic                 line_done_r;
  logic                 line_done_s;

  // A loader beat is taken only while the registered ready is presented.
  assign beat_s = (state_r == ST_LOAD) && ld_valid && ld_ready_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; abort overrides everything, including a new request.
  always_comb begin
    state_s = state_r;
    if (abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (line_req) begin
            state_s = ST_LOAD;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          // Leave one cycle after the last beat so its write strobe is not
          // overlapped by the transmit window.
          if (wr_cnt_r == WR_ALL) begin
            state_s = ST_TX;
          end else begin
            state_s = ST_LOAD;
          end
        end
        ST_TX: begin
          if (tx_cnt_r == TX_LAST) begin
            state_s = ST_RX;
          end else begin
            state_s = ST_TX;
          end
        end
        ST_RX: begin
          if (rx_cnt_r == RX_LAST) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RX;
          end
        end
        ST_DONE: state_s = ST_IDLE;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Phase counters: each runs only while its phase continues, else clears.
  always_comb begin
    wr_cnt_s = '0;
    tx_cnt_s = '0;
    rx_cnt_s = '0;
    if (state_s == ST_LOAD) begin
      if (beat_s) begin
        wr_cnt_s = wr_cnt_r + CNT_WD'(1);
      end else begin
        wr_cnt_s = wr_cnt_r;
      end
    end else begin
      wr_cnt_s = '0;
    end
    if ((state_r == ST_TX) && (state_s == ST_TX)) begin
      tx_cnt_s = tx_cnt_r + CNT_WD'(1);
    end else begin
      tx_cnt_s = '0;
    end
    if ((state_r == ST_RX) && (state_s == ST_RX)) begin
      rx_cnt_s = rx_cnt_r + CNT_WD'(1);
    end else begin
      rx_cnt_s = '0;
    end
  end

  // Phase counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_r <= '0;
      tx_cnt_r <= '0;
      rx_cnt_r <= '0;
    end else begin
      wr_cnt_r <= wr_cnt_s;
      tx_cnt_r <= tx_cnt_s;
      rx_cnt_r <= rx_cnt_s;
    end
  end

  // The stepper is cleared on RX entry so the first RX cycle reads zone 0.
  assign zone_en_s  = (state_r == ST_RX) && (state_s == ST_RX);
  assign zone_clr_s = ~zone_en_s;

  dbf_zone_addr_gen #(
    .ADDR_WD   (ADDR_WD),
    .CNT_WD    (CNT_WD),
    .NUM_ZONES (NUM_ZONES),
    .ZONE_LEN  (ZONE_LEN)
  ) u_zone_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (zone_clr_s),
    .en       (zone_en_s),
    .addr_nxt (zone_addr_s)
  );

  // Next output values, decoded from the state being entered.
  always_comb begin
    ld_ready_s  = (state_s == ST_LOAD) && (wr_cnt_s != WR_ALL);
    lut_we_s    = (state_s == ST_LOAD) && beat_s;
    tx_en_s     = (state_s == ST_TX);
    start_s     = (state_s == ST_RX);
    busy_s      = (state_s != ST_IDLE);
    line_done_s = (state_s == ST_DONE);
    if (lut_we_s) begin
      lut_addr_s = wr_cnt_r[ADDR_WD-1:0];
    end else if (state_s == ST_RX) begin
      lut_addr_s = zone_addr_s;
    end else begin
      lut_addr_s = '0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_ready_r  <= 1'b0;
      lut_addr_r  <= '0;
      lut_we_r    <= 1'b0;
      tx_en_r     <= 1'b0;
      start_r     <= 1'b0;
      busy_r      <= 1'b0;
      line_done_r <= 1'b0;
    end else begin
      ld_ready_r  <= ld_ready_s;
      lut_addr_r  <= lut_addr_s;
      lut_we_r    <= lut_we_s;
      tx_en_r     <= tx_en_s;
      start_r     <= start_s;
      busy_r      <= busy_s;
      line_done_r <= line_done_s;
    end
  end

  assign ld_ready     = ld_ready_r;
  assign dbf_lut_addr = lut_addr_r;
  assign dbf_lut_we   = lut_we_r;
  assign tx_en        = tx_en_r;
  assign start        = start_r;
  assign busy         = busy_r;
  assign line_done    = line_done_r;

endmodule
